// File: rtl/bcache_pkg.sv
// bcache_pkg: shared counter encodings for the branch target cache
package bcache_pkg;
   typedef logic [1:0] bc_ctr_t;
   localparam bc_ctr_t BC_SNT = 2'b00;
   localparam bc_ctr_t BC_WNT = 2'b01;
   localparam bc_ctr_t BC_WT  = 2'b10;
   localparam bc_ctr_t BC_ST  = 2'b11;
   localparam bc_ctr_t BC_ALLOC_CTR = BC_WT;
endpackage

// File: rtl/bcache_if.sv
// bcache_if: lookup and REG1 update port bundle of the branch target cache
interface bcache_if;
   logic [31:0] current_pc;
   logic        lookup_en;
   logic        do_bcache;
   logic [31:0] bcache_pc;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush_all;
   modport master (output current_pc, lookup_en, upd_valid, upd_pc, upd_taken, upd_target, flush_all,
                   input do_bcache, bcache_pc);
   modport slave (input current_pc, lookup_en, upd_valid, upd_pc, upd_taken, upd_target, flush_all,
                  output do_bcache, bcache_pc);
endinterface

// File: rtl/bcache_sat_ctr2.sv
// bc_sat_ctr2: 2-bit saturating branch direction counter step
module bc_sat_ctr2
   import bcache_pkg::*;
(
   input  bc_ctr_t ctr_in,
   input  logic    taken,
   output bc_ctr_t ctr_out
);
   // move one step toward the resolved direction, holding at the ends
   always_comb begin
      ctr_out = taken ? ((ctr_in == BC_ST) ? BC_ST : ctr_in + 2'd1)
                      : ((ctr_in == BC_SNT) ? BC_SNT : ctr_in - 2'd1);
   end
endmodule

// File: rtl/bcache.sv
// bcache: direct-mapped branch target cache with combinational lookup and falling-edge training
module bcache
   import bcache_pkg::*;
#(
   parameter int ENTRIES = 8
) (
   input logic     clock,
   input logic     reset,
   bcache_if.slave bus
);
   localparam int IDX = $clog2(ENTRIES);
   logic [ENTRIES-1:0] valid;
   logic [29-IDX:0]    tag    [ENTRIES];
   logic [31:0]        target [ENTRIES];
   bc_ctr_t            ctr    [ENTRIES];
   logic [IDX-1:0]     lk_idx;
   logic [IDX-1:0]     up_idx;
   logic               lk_hit;
   logic               up_hit;
   bc_ctr_t            ctr_nx;
   logic               unused_lo;
   assign unused_lo = ^{bus.current_pc[1:0], bus.upd_pc[1:0]};
   // lookup reads the pre-edge table; no bypass from a same-cycle update
   always_comb begin
      lk_idx        = bus.current_pc[IDX+1:2];
      up_idx        = bus.upd_pc[IDX+1:2];
      lk_hit        = bus.lookup_en & valid[lk_idx] & (tag[lk_idx] == bus.current_pc[31:IDX+2]);
      up_hit        = valid[up_idx] & (tag[up_idx] == bus.upd_pc[31:IDX+2]);
      bus.do_bcache = lk_hit & ctr[lk_idx][1];
      bus.bcache_pc = bus.do_bcache ? target[lk_idx] : 32'b0;
   end
   bc_sat_ctr2 u_ctr (
      .ctr_in  (ctr[up_idx]),
      .taken   (bus.upd_taken),
      .ctr_out (ctr_nx)
   );
   // table state moves with the PC register on the falling edge; reset beats flush beats update
   always_ff @(negedge clock) begin
      if (reset) begin
         valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            ctr[i]    <= BC_SNT;
            target[i] <= '0;
         end
      end else if (bus.flush_all) begin
         valid <= '0;
      end else if (bus.upd_valid) begin
         if (up_hit) begin
            ctr[up_idx] <= ctr_nx;
            if (bus.upd_taken) target[up_idx] <= bus.upd_target;
         end else if (bus.upd_taken) begin
            valid[up_idx]  <= 1'b1;
            tag[up_idx]    <= bus.upd_pc[31:IDX+2];
            target[up_idx] <= bus.upd_target;
            ctr[up_idx]    <= BC_ALLOC_CTR;
         end
      end
   end
endmodule
